message_matcher: RTL and testbench
==================================

Name: message_matcher

Overview:
- Receive-side counterpart of the fixed 16-byte greeting transmitter: watches the byte stream from the UART receiver and detects each complete, in-order occurrence of the message "Hello \n\rWorld!\n\r".
- Sits between the UART RX deserializer and status logic (LEDs or a loopback checker).
- Reports match pulses, a saturating match count, and inter-byte timeouts.

Parameters:
- TIMEOUT_CYCLES, 50000, idle clock cycles allowed between bytes during a partial match before the match is abandoned; legal range 2..65535.
- COUNT_W, 8, width of match_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; valid only when new_rx_data=1.
- new_rx_data  input  1  single-cycle strobe; the byte is accepted on this cycle, with no backpressure.
- match  output  1  one-cycle pulse when the 16th message byte has been matched.
- match_count  output  COUNT_W  number of completed matches; saturates at all-ones.
- index  output  4  number of message bytes matched so far (0..15).
- busy  output  1  high when index != 0.
- timeout  output  1  one-cycle pulse when a partial match is abandoned because of the idle limit.

Behaviour:
- Reset (rst=1 at a clk edge): index=0, match=0, match_count=0, timeout=0, idle counter=0. Reset overrides a byte arriving on the same cycle. Reset in mid-match discards progress.
- Message constant: MSG[0..15] = 'H','e','l','l','o',' ',8'h0A,8'h0D,'W','o','r','l','d','!',8'h0A,8'h0D.
- The expected byte MSG[index] is a combinational lookup, so there is no lookup latency.
- States are encoded by index: IDLE (index=0) and MATCHING (index 1..15).
- On new_rx_data=1, compare rx_data with MSG[index]:
  - Equal and index<15: index <= index+1.
  - Equal and index==15: index <= 0, and match pulses high the next cycle. match_count increments unless it is already all-ones.
  - Not equal: if rx_data == MSG[0] ('H'), then index <= 1; otherwise index <= 0. 'H' never recurs in MSG, so this restart is exact and no general prefix table is needed.
- Latency: match and all index updates are registered and visible one cycle after the accepting edge.
- Back-to-back bytes (new_rx_data high on consecutive cycles) are all processed.
- Idle counter (16 bits):
  - Cleared on every accepted byte and whenever index==0.
  - Otherwise increments once per cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no byte on that cycle: index <= 0, counter <= 0, and timeout pulses for one cycle.
  - If a byte arrives on the threshold cycle, the byte wins: it is processed normally and no timeout is raised.
- match and timeout can never be asserted in the same cycle.
- busy is a combinational function of registered index.

Optional Feature:
- Macro MESSAGE_MATCHER_CASE_FOLD_EN.
  - Defined: before comparing, both rx_data and MSG[index] are folded so that 8'h41..8'h5A map to 8'h61..8'h7A. "HELLO \n\rworld!\n\r" then matches. Restart detection also accepts 'h'.
  - Undefined: exact 8-bit compare only, and there is no folding logic in the netlist.

Decomposition:
- Package message_pkg holds:
  - MSG_LEN=16 and the MSG byte array constant.
  - The CR/LF localparams.
  - The state encoding localparams.
- Sub-module message_char_lut: combinational 4-bit index to 8-bit expected byte. It is shareable with the transmitter path.
- Compare, restart, and timeout logic stay in message_matcher.

Test Plan:
- Full message: send the 16 MSG bytes with 3-cycle gaps → match pulses exactly once, 1 cycle after the 16th byte; match_count=1; index=0 afterwards.
- Restart on 'H': send "HelHello \n\rWorld!\n\r" → index goes 1,2,3, then 1 on the second 'H'; exactly one match; match_count=1.
- Garbage and back-to-back: send 'x', 'H', 'e', 'Q', then a full message with new_rx_data held high for 16 consecutive cycles → index=0 after 'Q'; one match; no timeout.
- Timeout: with TIMEOUT_CYCLES=8, send "Hel" then idle 20 cycles → timeout pulses once, 8 cycles after the last byte; index=0. Repeat with a byte on exactly the threshold cycle → no timeout, and the byte is processed.
- Saturation and reset: with COUNT_W=2, send 5 full messages → match_count sequence 1,2,3,3,3. Assert rst mid-message after "Hello" → index=0 and match_count=0 the next cycle, and the remainder of the message produces no match.
- Case fold: with MESSAGE_MATCHER_CASE_FOLD_EN defined, "hELLO \n\rWORLD!\n\r" → one match. Without the macro, the same stimulus → no match, and index returns to 0 after 'h'.

Source files
------------

// File: rtl/message_pkg.sv
// message_pkg: message constant, control characters and index-based state encoding shared by matcher and transmitter
package message_pkg;
    localparam int MSG_LEN = 16;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [0:MSG_LEN-1][7:0] MSG = {"Hello ", LF, CR, "World!", LF, CR};
    localparam logic [3:0] IDX_IDLE = 4'd0;
    localparam logic [3:0] IDX_LAST = 4'(MSG_LEN - 1);
endpackage

// File: rtl/message_char_lut.sv
// message_char_lut: combinational lookup of the expected message byte at a given position
module message_char_lut
    import message_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] ch
);
    assign ch = MSG[idx];
endmodule

// File: rtl/message_matcher.sv
// message_matcher: detects in-order "Hello \n\rWorld!\n\r" in an RX byte stream, with idle timeout; MESSAGE_MATCHER_CASE_FOLD_EN enables ASCII case-insensitive compare
module message_matcher
    import message_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               new_rx_data,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic [3:0]         index,
    output logic               busy,
    output logic               timeout
);
    logic [7:0]  exp_ch, rx_c, exp_c, h_c;
    logic [15:0] idle_cnt, idle_cnt_nxt;
    logic [3:0]  index_nxt;
    logic        eq, restart, hit, idle_hit;

    message_char_lut u_lut (.idx(index), .ch(exp_ch));

`ifdef MESSAGE_MATCHER_CASE_FOLD_EN
    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction
    assign rx_c  = fold(rx_data);
    assign exp_c = fold(exp_ch);
    assign h_c   = fold(MSG[0]);
`else
    assign rx_c  = rx_data;
    assign exp_c = exp_ch;
    assign h_c   = MSG[0];
`endif

    assign busy = index != IDX_IDLE;

    // compare/restart/timeout decisions; 'H' never recurs so restart needs no prefix table
    always_comb begin
        eq           = rx_c == exp_c;
        restart      = rx_c == h_c;
        hit          = new_rx_data && eq && index == IDX_LAST;
        idle_hit     = !new_rx_data && busy && idle_cnt == 16'(TIMEOUT_CYCLES - 1);
        index_nxt    = new_rx_data ? (eq ? (hit ? IDX_IDLE : index + 4'd1) : (restart ? 4'd1 : IDX_IDLE))
                                   : (idle_hit ? IDX_IDLE : index);
        idle_cnt_nxt = (new_rx_data || !busy || idle_hit) ? 16'd0 : idle_cnt + 16'd1;
    end

    // registered progress, pulses and saturating match counter
    always_ff @(posedge clk) begin
        if (rst) begin
            index       <= IDX_IDLE;
            idle_cnt    <= 16'd0;
            match       <= 1'b0;
            timeout     <= 1'b0;
            match_count <= '0;
        end else begin
            index    <= index_nxt;
            idle_cnt <= idle_cnt_nxt;
            match    <= hit;
            timeout  <= idle_hit;
            if (hit && !(&match_count))
                match_count <= match_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_message_matcher.sv
// tb_message_matcher: directed and random stimulus against a history-buffer reference model
module tb_message_matcher;
    localparam int T = 8;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 0, rst = 0, new_rx_data = 0;
    logic [7:0]    rx_data = 0;
    logic          match, busy, timeout;
    logic [CW-1:0] match_count;
    logic [3:0]    index;

    message_matcher #(.TIMEOUT_CYCLES(T), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .match(match), .match_count(match_count), .index(index), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    string msg_s = "Hello \n\rWorld!\n\r";
    logic [7:0] hist[$];
    int total = 0, bad = 0;
    int mk = 0, mc = 0, gap = 0;
    int n_match = 0, n_to = 0;

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef MESSAGE_MATCHER_CASE_FOLD_EN
        return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
`else
        return c;
`endif
    endfunction

    function automatic logic [7:0] mch(input int i);
        return msg_s[i];
    endfunction

    // longest suffix of the received history that is a prefix of the message
    function automatic int pref();
        int n = hist.size();
        for (int l = (n < 16 ? n : 16); l > 0; l--) begin
            bit ok = 1;
            for (int i = 0; i < l; i++)
                if (fold(hist[n-l+i]) != fold(mch(i))) ok = 0;
            if (ok) return l;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d);
        bit em, et;
        rst = r; new_rx_data = v; rx_data = d;
        @(posedge clk);
        em = 0; et = 0;
        if (r) begin
            hist.delete(); mk = 0; mc = 0; gap = 0;
        end else if (v) begin
            hist.push_back(d);
            while (hist.size() > 16) void'(hist.pop_front());
            gap = 0;
            mk = pref();
            if (mk == 16) begin
                em = 1; mk = 0; hist.delete();
                if (mc < MAXC) mc++;
            end
        end else begin
            gap++;
            if (mk > 0 && gap == T) begin
                et = 1; mk = 0; hist.delete();
            end
        end
        #1;
        chk("index", 32'(index), 32'(mk));
        chk("busy", 32'(busy), 32'(mk > 0));
        chk("match", 32'(match), 32'(em));
        chk("timeout", 32'(timeout), 32'(et));
        chk("match_count", 32'(match_count), 32'(mc));
        if (match === 1'b1) n_match++;
        if (timeout === 1'b1) n_to++;
    endtask

    task automatic send(input logic [7:0] d);
        step(0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        int cseq[5] = '{1, 2, 3, 3, 3};
        int to_at;
        string fs = "hELLO \n\rWORLD!\n\r";

        step(1, 1, "H");
        step(1, 0, 8'h00);
        chk("reset_index", 32'(index), 0);
        chk("reset_count", 32'(match_count), 0);

        n_match = 0;
        for (int i = 0; i < 16; i++) begin
            send(mch(i));
            idle(3);
        end
        chk("full_matches", n_match, 1);
        chk("full_count", 32'(match_count), 1);

        step(1, 0, 8'h00);
        n_match = 0;
        send_str("HelHello \n\rWorld!\n\r");
        idle(1);
        chk("restart_matches", n_match, 1);

        step(1, 0, 8'h00);
        n_match = 0; n_to = 0;
        send_str("xHeQ");
        chk("garbage_index", 32'(index), 0);
        send_str(msg_s);
        idle(2);
        chk("b2b_matches", n_match, 1);
        chk("b2b_timeouts", n_to, 0);

        step(1, 0, 8'h00);
        n_to = 0; to_at = -1;
        send_str("Hel");
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 8'h00);
            if (timeout === 1'b1 && to_at < 0) to_at = i;
        end
        chk("timeout_count", n_to, 1);
        chk("timeout_at", to_at, T);
        chk("timeout_index", 32'(index), 0);

        n_to = 0;
        send_str("Hel");
        idle(T - 1);
        send("l");
        chk("thresh_timeouts", n_to, 0);
        chk("thresh_index", 32'(index), 4);

        step(1, 0, 8'h00);
        for (int m = 0; m < 5; m++) begin
            send_str(msg_s);
            idle(1);
            chk("sat_count", 32'(match_count), cseq[m]);
        end

        send_str("Hello");
        step(1, 1, " ");
        chk("rst_mid_index", 32'(index), 0);
        chk("rst_mid_count", 32'(match_count), 0);
        n_match = 0;
        for (int i = 5; i < 16; i++) send(mch(i));
        idle(1);
        chk("rst_mid_matches", n_match, 0);

        n_match = 0;
        send("h");
`ifndef MESSAGE_MATCHER_CASE_FOLD_EN
        chk("nofold_h_index", 32'(index), 0);
`endif
        for (int i = 1; i < 16; i++) send(fs[i]);
        idle(1);
`ifdef MESSAGE_MATCHER_CASE_FOLD_EN
        chk("fold_matches", n_match, 1);
`else
        chk("fold_matches", n_match, 0);
`endif

        for (int s = 0; s < 3000; s++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) step(1, $urandom_range(0, 1), 8'(mch(0)));
            else if (r < 62) begin
                int q = $urandom_range(0, 9);
                send(q < 7 ? mch(mk) : (q < 8 ? 8'h48 : 8'($urandom_range(0, 255))));
            end else idle(r > 97 ? $urandom_range(T - 2, T + 2) : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
